// File: rtl/pixel_countdown_overlay_if.sv
// Bundle of the countdown control handshake and the VGA pixel stream for
// pixel_countdown_overlay; the overlay block is the slave side.
interface pixel_countdown_overlay_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  pause;
    logic [4*DIGITS-1:0]   load_bcd;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sec_bcd;
    logic                  video_on;
    logic [10:0]           x;
    logic [10:0]           y;
    logic [11:0]           rgb;

    modport master (
        output start, pause, load_bcd, video_on, x, y,
        input  busy, done, sec_bcd, rgb
    );

    modport slave (
        input  start, pause, load_bcd, video_on, x, y,
        output busy, done, sec_bcd, rgb
    );
endinterface

// File: rtl/pixel_countdown_overlay.sv
// BCD countdown with one-second prescaler and a scaled-glyph VGA overlay
// ("N..0" then "GO!") over a checkerboard, two-stage pixel pipeline.
module pixel_countdown_overlay #(
    parameter int          DIGITS   = 2,
    parameter int          TICK_DIV = 40_000_000,
    parameter int          GO_TICKS = 2,
    parameter int          SCALE    = 2,
    parameter int          ORG_X    = 368,
    parameter int          ORG_Y    = 256,
    parameter int          CHECK    = 80,
    parameter logic [11:0] FG       = 12'hFFF,
    parameter logic [11:0] BG_A     = 12'h0F0,
    parameter logic [11:0] BG_B     = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pixel_countdown_overlay_if.slave  bus,
    output logic [1:0]                dbg_state_o
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GO_TICKS > 0) ? $clog2(GO_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GO_LAST  = GW'(GO_TICKS - 1);
    localparam logic [10:0]   X_LO     = 11'(ORG_X);
    localparam logic [11:0]   X_HI     = 12'(ORG_X + DIGITS * (8 << SCALE));
    localparam logic [10:0]   Y_LO     = 11'(ORG_Y);
    localparam logic [11:0]   Y_HI     = 12'(ORG_Y + (16 << SCALE));
    localparam logic [10:0]   CHECK_W  = 11'(CHECK);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GO} state_t;

    state_t        state_q;
    logic [W-1:0]  cnt_q;
    logic [PW-1:0] pre_q;
    logic [GW-1:0] go_q;
    logic          done_q;
    logic          tick_w;

    logic [W-1:0]  shd_val_q;
    logic          shd_go_q;

    logic [10:0]   gsel_w;
    logic [6:0]    char_d;
    logic [3:0]    row_d;
    logic [2:0]    bit_d;
    logic          region_d;
    logic [11:0]   checker_d;

    logic [7:0]    word_q;
    logic [2:0]    bit_q;
    logic          region_q;
    logic [11:0]   checker_q;
    logic          von_q;
    logic [11:0]   rgb_q;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // 8x16 glyphs, row 0 in the top byte, leftmost pixel in bit 7.
    function automatic logic [127:0] glyph(input logic [6:0] ch);
        case (ch)
            7'h30:   glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            7'h31:   glyph = 128'h000018387818181818181818_7E000000 >> 0;
            7'h32:   glyph = 128'h00007CC6060C183060C0C6FE00000000;
            7'h33:   glyph = 128'h00007CC606063C060606C67C00000000;
            7'h34:   glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            7'h35:   glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
            7'h36:   glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
            7'h37:   glyph = 128'h0000FEC606060C183030303000000000;
            7'h38:   glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            7'h39:   glyph = 128'h00007CC6C6C67E0606060C7800000000;
            7'h47:   glyph = 128'h00003C66C2C0C0DEC6C6663A00000000;
            7'h4F:   glyph = 128'h00007CC6C6C6C6C6C6C6C67C00000000;
            7'h21:   glyph = 128'h0000183C3C3C181818001818_00000000 >> 0;
            default: glyph = '0;
        endcase
    endfunction

    function automatic logic [7:0] rom_word(input logic [10:0] addr);
        logic [127:0] g;
        g = glyph(addr[10:4]);
        return 8'(g >> {~addr[3:0], 3'b000});
    endfunction

    // Control handshake: start is a one-cycle request that is always accepted
    // (even while busy or paused) and acknowledged by busy from the next cycle;
    // done pulses for one cycle as the GO banner expires and busy drops.
    assign tick_w = (state_q != S_IDLE) && !bus.pause && (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            go_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                state_q <= S_COUNT;
                cnt_q   <= clamp_bcd(bus.load_bcd);
                pre_q   <= '0;
                go_q    <= '0;
            end else if (state_q != S_IDLE && !bus.pause) begin
                pre_q <= tick_w ? '0 : pre_q + 1'b1;
                if (tick_w) begin
                    if (state_q == S_COUNT) begin
                        if (cnt_q != '0) begin
                            cnt_q <= dec_bcd(cnt_q);
                        end else begin
                            state_q <= S_GO;
                            go_q    <= '0;
                        end
                    end else if (go_q == GO_LAST) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        go_q <= go_q + 1'b1;
                    end
                end
            end
        end
    end

    // Frame-start snapshot keeps a whole frame on one value and one state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_val_q <= '0;
            shd_go_q  <= 1'b0;
        end else if (bus.x == 11'd0 && bus.y == 11'd0) begin
            shd_val_q <= cnt_q;
            shd_go_q  <= (state_q == S_GO);
        end
    end

    assign gsel_w = (bus.x - X_LO) >> (3 + SCALE);

    always_comb begin : stage0
        logic [3:0] nib;
        logic       lz;
        nib       = 4'd0;
        lz        = 1'b1;
        char_d    = 7'h20;
        region_d  = ({1'b0, bus.x} >= {1'b0, X_LO}) && ({1'b0, bus.x} < X_HI) &&
                    ({1'b0, bus.y} >= {1'b0, Y_LO}) && ({1'b0, bus.y} < Y_HI);
        row_d     = 4'((bus.y - Y_LO) >> SCALE);
        bit_d     = 3'((bus.x - X_LO) >> SCALE);
        checker_d = (1'(bus.x / CHECK_W) ^ 1'(bus.y / CHECK_W)) ? BG_B : BG_A;
        // Digits scan MSB first so lz tracks "every digit so far is zero".
        for (int g = 0; g < DIGITS; g++) begin
            nib = shd_val_q[4*(DIGITS-1-g) +: 4];
            lz  = lz & (nib == 4'd0);
            if (gsel_w == 11'(g)) begin
                if (shd_go_q)
                    char_d = (g == 0) ? 7'h47 : (g == 1) ? 7'h4F : (g == 2) ? 7'h21 : 7'h20;
                else if (lz && g != DIGITS - 1)
                    char_d = 7'h20;
                else
                    char_d = {3'b011, nib};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            bit_q     <= '0;
            region_q  <= 1'b0;
            checker_q <= '0;
            von_q     <= 1'b0;
            rgb_q     <= '0;
        end else begin
            word_q    <= rom_word({char_d, row_d});
            bit_q     <= bit_d;
            region_q  <= region_d;
            checker_q <= checker_d;
            von_q     <= bus.video_on;
            if (!von_q)
                rgb_q <= '0;
            else if (region_q && word_q[~bit_q])
                rgb_q <= FG;
            else
                rgb_q <= checker_q;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.sec_bcd = cnt_q;
    assign bus.rgb     = rgb_q;
    assign dbg_state_o = state_q;
endmodule
